// File: rtl/posit_mult_arbiter.sv
// posit_mult_arbiter: round-robin sharing of one pipelined 32-bit posit
// multiplier among NREQ requesters, with a tag pipeline that routes each
// product back to a one-deep per-requester result slot.

// Per-requester result slot: occupancy flags plus captured product.
module posit_mult_arbiter_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic        retire,
  input  logic        res_ready,
  input  logic [31:0] mult_result,
  input  logic        mult_inf,
  input  logic        mult_zero,
  output logic        busy,
  output logic        res_valid,
  output logic [31:0] res_result,
  output logic        res_inf,
  output logic        res_zero
);
  logic consume;
  assign consume = res_valid & res_ready;

  // busy spans grant..consume; valid spans retire..consume
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      if (accept)       busy <= 1'b1;
      else if (consume) busy <= 1'b0;
      if (retire)       res_valid <= 1'b1;
      else if (consume) res_valid <= 1'b0;
    end

  // capture product on retire; data is left in place after consume
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      res_result <= '0;
      res_inf    <= 1'b0;
      res_zero   <= 1'b0;
    end else if (retire) begin
      res_result <= mult_result;
      res_inf    <= mult_inf;
      res_zero   <= mult_zero;
    end
endmodule

module posit_mult_arbiter #(
  parameter int NREQ     = 4,
  parameter int MULT_LAT = 4,
  parameter int TAGW     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_in1,
  input  logic [NREQ*32-1:0] req_in2,
  output logic [NREQ-1:0]    res_valid,
  input  logic [NREQ-1:0]    res_ready,
  output logic [NREQ*32-1:0] res_result,
  output logic [NREQ-1:0]    res_inf,
  output logic [NREQ-1:0]    res_zero,
  output logic               mult_start,
  output logic [31:0]        mult_in1,
  output logic [31:0]        mult_in2,
  input  logic [31:0]        mult_result,
  input  logic               mult_inf,
  input  logic               mult_zero,
  input  logic               mult_done,
  output logic [NREQ-1:0]    busy,
  output logic               err_sync
);
  localparam int FW = $clog2(MULT_LAT + 2);

  logic [FW-1:0]               flush_cnt;
  logic                        flushing, retire_en, gnt_any;
  logic [TAGW-1:0]             rr_ptr, gnt_idx;
  logic [TAGW:0]               gnt_sum;
  logic [NREQ-1:0]             elig, elig_rot, retire;
  // [0] is registered alongside mult_start, [MULT_LAT] lines up with mult_done
  logic [MULT_LAT:0]           vld_pipe;
  logic [MULT_LAT:0][TAGW-1:0] tag_pipe;

  assign flushing  = (flush_cnt != '0);
  assign elig      = req_valid & ~busy & {NREQ{~flushing}};
  assign retire_en = mult_done & vld_pipe[MULT_LAT] & ~flushing;

  // grant the first eligible requester at or after rr_ptr, wrapping mod NREQ
  always_comb begin
    elig_rot = NREQ'({elig, elig} >> rr_ptr);
    gnt_any  = 1'b0;
    gnt_sum  = '0;
    for (int off = NREQ - 1; off >= 0; off--)
      if (elig_rot[off]) begin
        gnt_any = 1'b1;
        gnt_sum = {1'b0, rr_ptr} + (TAGW+1)'(off);
      end
    if (gnt_sum >= (TAGW+1)'(NREQ)) gnt_sum = gnt_sum - (TAGW+1)'(NREQ);
    gnt_idx   = gnt_sum[TAGW-1:0];
    req_ready = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
  end

  // issue: register operands and start pulse, advance round-robin pointer
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rr_ptr     <= '0;
      mult_start <= 1'b0;
      mult_in1   <= '0;
      mult_in2   <= '0;
    end else begin
      mult_start <= gnt_any;
      if (gnt_any) begin
        mult_in1 <= req_in1[32*gnt_idx +: 32];
        mult_in2 <= req_in2[32*gnt_idx +: 32];
        rr_ptr   <= (gnt_idx == TAGW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end

  // tag pipeline shadows the multiplier so each done knows its owner
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[MULT_LAT-1:0], gnt_any};
      tag_pipe <= {tag_pipe[MULT_LAT-1:0], gnt_idx};
    end

  // post-reset flush window (multiplier is not reset) and sticky sync check
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      flush_cnt <= FW'(MULT_LAT + 1);
      err_sync  <= 1'b0;
    end else if (flushing) begin
      flush_cnt <= flush_cnt - 1'b1;
    end else if (mult_done != vld_pipe[MULT_LAT]) begin
      err_sync <= 1'b1;
    end

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign retire[i] = retire_en && (tag_pipe[MULT_LAT] == TAGW'(i));
    posit_mult_arbiter_slot u_slot (
      .clk         (clk),
      .reset       (reset),
      .accept      (req_ready[i]),
      .retire      (retire[i]),
      .res_ready   (res_ready[i]),
      .mult_result (mult_result),
      .mult_inf    (mult_inf),
      .mult_zero   (mult_zero),
      .busy        (busy[i]),
      .res_valid   (res_valid[i]),
      .res_result  (res_result[32*i +: 32]),
      .res_inf     (res_inf[i]),
      .res_zero    (res_zero[i])
    );
  end
endmodule
